// File: rtl/fir_band_scheduler.sv
// ---------------------------------------------------------------------------
// fir_band_scheduler
//
// Time-multiplexed FIR controller. One shared sign-magnitude multiply-
// accumulate datapath is sequenced across up to BANDS bands of ORDER taps.
// Each accepted sample is written into a shared circular delay line, then
// every enabled band's coefficient set is streamed from an external
// coefficient memory and one result per band is emitted.
//
// Optional feature macro:
//   FIR_SCHED_SAT_EN  defined   -> result magnitude saturates at 18'h3FFFF
//                     undefined -> result magnitude wraps (low 18 bits of |acc|)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   sample_valid   sample_in is offered this cycle
//   sample_in      10-bit sign-magnitude sample (bit 9 sign, [8:0] magnitude)
//   sample_ready   high only in IDLE; accept = sample_valid && sample_ready
//   band_en        band enable mask, captured in the WRITE cycle
//   coef_rd        coefficient read strobe
//   coef_addr      band*ORDER + tap
//   coef_data      sign-magnitude coefficient, valid the cycle after coef_rd
//   band_valid     one-cycle result pulse
//   band_idx       band index of the current result
//   band_out       bits [18:9] of the 19-bit sign-magnitude result
//   band_out_full  full 19-bit sign-magnitude result
//   busy           high whenever not in IDLE
//   overrun        sticky: a sample was offered while busy (cleared by rst)
// ---------------------------------------------------------------------------
module fir_band_scheduler #(
    parameter int ORDER = 30,
    parameter int BANDS = 4,
    parameter int CAW   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [9:0]       sample_in,
    output logic             sample_ready,
    input  logic [BANDS-1:0] band_en,
    output logic             coef_rd,
    output logic [CAW-1:0]   coef_addr,
    input  logic [9:0]       coef_data,
    output logic             band_valid,
    output logic [1:0]       band_idx,
    output logic [9:0]       band_out,
    output logic [18:0]      band_out_full,
    output logic             busy,
    output logic             overrun
);

    localparam int PW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [PW-1:0] TAP_LAST = PW'(ORDER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT
    } state_t;

    state_t state_q, state_nxt;

    logic [PW-1:0]    tap_q;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    newest_q;
    logic [1:0]       band_q;
    logic [BANDS-1:0] en_q;          // enabled bands still waiting their turn
    logic [9:0]       sample_q;
    logic [9:0]       dline [ORDER];
    logic [9:0]       x_q;
    logic             prod_vld_q;
    logic [23:0]      acc_q;
    logic             band_valid_q;
    logic [1:0]       band_idx_q;
    logic [18:0]      result_q;
    logic             overrun_q;

    logic [PW-1:0]    rd_idx;
    logic [17:0]      prod_mag;
    logic [23:0]      prod_ext;
    logic [23:0]      prod_s;
    logic [23:0]      acc_sum;
    logic [17:0]      mag18;
    logic [18:0]      res_sm;

    // Index of the lowest set bit of a band mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_band(input logic [BANDS-1:0] mask);
        logic [1:0] idx;
        idx = '0;
        for (int i = BANDS - 1; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Mask with its lowest set bit removed.
    function automatic logic [BANDS-1:0] drop_lowest(input logic [BANDS-1:0] mask);
        return mask & (mask - BANDS'(1));
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (sample_valid) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (band_en == '0) ? S_IDLE : S_ISSUE;
            S_ISSUE: if (tap_q == TAP_LAST) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_EMIT;
            S_EMIT:  state_nxt = (en_q == '0) ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        sample_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        coef_rd      = (state_q == S_ISSUE);
        coef_addr    = '0;
        if (state_q == S_ISSUE) begin
            coef_addr = CAW'(int'(band_q) * ORDER + int'(tap_q));
        end
    end

    // Delay-line slot holding x[n-k]: (newest - k) mod ORDER. When the
    // subtraction would go negative, add ORDER back; the PW-bit arithmetic
    // keeps this correct whether or not ORDER is a power of two.
    always_comb begin
        if (tap_q <= newest_q) rd_idx = newest_q - tap_q;
        else                   rd_idx = PW'(ORDER) + newest_q - tap_q;
    end

    // -----------------------------------------------------------------------
    // Sign-magnitude multiply, two's-complement accumulate
    // -----------------------------------------------------------------------
    always_comb begin
        prod_mag = 18'(x_q[8:0]) * 18'(coef_data[8:0]);
        prod_ext = {6'b0, prod_mag};
        // A zero magnitude negates to zero, so negative-zero operands vanish.
        prod_s   = (x_q[9] ^ coef_data[9]) ? -prod_ext : prod_ext;
        acc_sum  = acc_q + prod_s;
    end

    // Accumulator to 19-bit sign-magnitude.
`ifdef FIR_SCHED_SAT_EN
    logic [23:0] abs24;
    always_comb begin
        abs24 = acc_sum[23] ? -acc_sum : acc_sum;
        mag18 = (|abs24[23:18]) ? 18'h3FFFF : abs24[17:0];
    end
`else
    // Low bits of |acc| depend only on the low bits of acc, so the wrapped
    // magnitude is the 18-bit negation of the low slice.
    always_comb begin
        mag18 = acc_sum[23] ? -acc_sum[17:0] : acc_sum[17:0];
    end
`endif

    // A zero magnitude is always reported with a positive sign.
    assign res_sm = {acc_sum[23] && (mag18 != '0), mag18};

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            wptr_q       <= '0;
            newest_q     <= '0;
            band_q       <= '0;
            en_q         <= '0;
            sample_q     <= '0;
            x_q          <= '0;
            prod_vld_q   <= 1'b0;
            acc_q        <= '0;
            band_valid_q <= 1'b0;
            band_idx_q   <= '0;
            result_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            prod_vld_q   <= (state_q == S_ISSUE);
            band_valid_q <= (state_q == S_DRAIN);
            overrun_q    <= overrun_q | (sample_valid & ~sample_ready);

            if (state_q == S_WRITE || state_q == S_EMIT) acc_q <= '0;
            else if (prod_vld_q)                         acc_q <= acc_sum;

            case (state_q)
                S_IDLE: begin
                    if (sample_valid) sample_q <= sample_in;
                end
                S_WRITE: begin
                    newest_q <= wptr_q;
                    wptr_q   <= (wptr_q == TAP_LAST) ? '0 : wptr_q + PW'(1);
                    band_q   <= lowest_band(band_en);
                    en_q     <= drop_lowest(band_en);
                    tap_q    <= '0;
                end
                S_ISSUE: begin
                    x_q   <= dline[rd_idx];
                    tap_q <= tap_q + PW'(1);
                end
                S_DRAIN: begin
                    result_q   <= res_sm;
                    band_idx_q <= band_q;
                end
                S_EMIT: begin
                    tap_q <= '0;
                    if (en_q != '0) begin
                        band_q <= lowest_band(en_q);
                        en_q   <= drop_lowest(en_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Delay line. NOTE: this memory is deliberately cleared by reset so that a
    // reset mid-stream leaves no stale history feeding later results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) dline[i] <= '0;
        end else if (state_q == S_WRITE) begin
            dline[wptr_q] <= sample_q;
        end
    end

    assign band_valid    = band_valid_q;
    assign band_idx      = band_idx_q;
    assign band_out_full = result_q;
    assign band_out      = result_q[18:9];
    assign overrun       = overrun_q;

endmodule

// File: doc/fir_band_scheduler.md
# fir_band_scheduler

Time-multiplexed controller that sequences one shared sign-magnitude multiply-accumulate datapath across up to four FIR bands. On each accepted input sample it updates a shared circular delay line, then walks every enabled band's coefficient set from an external coefficient memory. It emits one filtered result per band in the same 10-bit fixed-point format the per-band filters produce. It replaces four parallel 30-tap filters in the 4-band design.

## Interface
- ORDER, 30, taps per band.
- BANDS, 4, number of bands (1..4).
- CAW, 7, coefficient address width; must be at least clog2(BANDS*ORDER).
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- sample_valid, input, 1, offers sample_in this cycle.
- sample_in, input, 10, sign-magnitude sample: bit9 is the sign, bits[8:0] the magnitude.
- sample_ready, output, 1, high only in IDLE; a sample is accepted when sample_valid && sample_ready.
- band_en, input, BANDS, band enable mask, captured in the WRITE cycle.
- coef_rd, output, 1, coefficient read strobe.
- coef_addr, output, CAW, band*ORDER + tap.
- coef_data, input, 10, sign-magnitude coefficient, valid the cycle after coef_rd.
- band_valid, output, 1, one-cycle result pulse.
- band_idx, output, 2, band index of the current result.
- band_out, output, 10, sm19[18:9] of the band result.
- band_out_full, output, 19, full 19-bit sign-magnitude band result.
- busy, output, 1, high when not in IDLE.
- overrun, output, 1, sticky flag; set when sample_valid && !sample_ready; cleared only by rst.

## Operation
- States: IDLE, WRITE, ISSUE, DRAIN, EMIT.
- IDLE -> WRITE on an accepted sample.
- WRITE:
  - store the sample at wptr; advance wptr mod ORDER.
  - latch band_en into en_q; select the lowest enabled band.
  - if en_q == 0, return to IDLE.
- ISSUE: ORDER cycles.
  - Tap k: coef_rd=1, coef_addr = b*ORDER + k, delay-line read of x[n-k] at (newest - k) mod ORDER.
  - Accumulate the product of tap k one cycle later.
- DRAIN: one cycle; accumulates the last tap.
- EMIT:
  - register the result; pulse band_valid.
  - go to ISSUE for the next enabled band, else to IDLE.
- Disabled bands consume no cycles.
- Arithmetic:
  - 9x9 magnitude multiply gives an 18-bit product; sign = XOR of the operand signs.
  - Accumulate in a 24-bit two's-complement register, cleared at the start of each band.
  - Convert to 19-bit sign-magnitude: magnitude bits[17:0] plus a sign bit. Overflow behaviour is set by Configuration.
- A zero result always has sign 0. Input negative zero (10'b1000000000) is treated as zero.
- Reset, including mid-operation:
  - state -> IDLE; the delay line (all ORDER entries) and wptr -> 0.
  - accumulator -> 0; overrun -> 0.
  - no partial band_valid is produced.
- Outputs after reset: sample_ready=1, busy=0, coef_rd=0, coef_addr=0, band_valid=0, band_idx=0, band_out=0, band_out_full=0, overrun=0.
- A sample offered while busy is dropped and sets overrun. The sequence in progress is unaffected.

## Timing
- Sample accepted at cycle 0.
- WRITE occupies cycle 1.
- For the j-th enabled band (j=0..): ISSUE occupies cycles 2+j*(ORDER+2) .. 1+j*(ORDER+2)+ORDER.
- That band's band_valid pulses at cycle 1+(j+1)*(ORDER+2).
- ORDER=30, all bands enabled: band_valid at cycles 33, 65, 97, 129; sample_ready high again at cycle 130.
- Minimum sample period: 2 + n_en*(ORDER+2) cycles.
- band_out, band_idx and band_out_full hold their value until the next EMIT.

## Configuration
- FIR_SCHED_SAT_EN defined: magnitudes above 18'h3FFFF clamp to 18'h3FFFF, sign preserved.
- FIR_SCHED_SAT_EN undefined: the magnitude wraps, keeping the low 18 bits of |acc|.

## Test plan
- Reset, then a single impulse: c0[0]=70, sample 256 (10'b0100000000), band_en=4'b0001.
  - Required: band_valid at cycle 33, band_idx=0, band_out_full=17920, band_out=10'b0000100011.
  - Next sample 0 with c0[1]=10'b1000001010 (-10): band_out_full = sign 1, magnitude 2560.
- Four bands enabled, distinct coefficients:
  - Required: pulses at cycles 33/65/97/129 with band_idx 0,1,2,3.
  - sample_ready stays low during cycles 1..129.
  - band_en=4'b1010: pulses at 33 (idx 1) and 65 (idx 3) only.
- Overrun: sample_valid pulse at cycle 10 of a busy sequence.
  - Required: that sample is dropped, overrun=1, results unchanged; overrun clears only on rst.
- Overflow: band0 all taps 511 (0x1FF), 30 consecutive samples of 511.
  - With SAT_EN: band_out=10'b0111111111.
  - Without SAT_EN: magnitude 231454, band_out=10'b0111000100.
- Reset mid-ISSUE (cycle 20):
  - Required: no band_valid is produced; all outputs return to their reset values.
  - After reset, an impulse test gives the same result as from power-up (delay line cleared).
- Delay-line wrap: 31 samples, with only sample 0 non-zero.
  - Required: its contribution uses c[k] on the k-th subsequent sample.
  - It vanishes on the 30th subsequent sample.
